// File: rtl/obi_uart_tx_arb.sv
// obi_uart_tx_arb
// OBI manager that shares one UART transmitter between NumReq byte-stream
// requesters. It polls the UART Line Status Register for THRE (bit 5); each
// observed THRE refills a credit of FifoDepth bytes. Requesters are then served
// round-robin, one Transmit Holding Register write per accepted byte.
//
// Optional feature macro: OBI_UART_TX_ARB_PRIO_EN
//   defined   : requester 0 has strict priority; round-robin among 1..NumReq-1.
//   undefined : pure round-robin across all requesters.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_valid_i/data_i  per-requester byte valid and byte (requester k at [8k+7:8k])
//   req_ready_o         one-hot, one-cycle byte-accepted strobe
//   obi_*               OBI manager port (single outstanding transaction)
//   busy_o              sequencer not idle
//   err_o               sticky: some OBI response returned err
module obi_uart_tx_arb #(
  parameter int unsigned NumReq    = 4,
  parameter logic [31:0] BaseAddr  = 32'h0000_0000,
  parameter int unsigned FifoDepth = 16,
  parameter int unsigned PollGap   = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumReq-1:0]   req_valid_i,
  input  logic [8*NumReq-1:0] req_data_i,
  output logic [NumReq-1:0]   req_ready_o,
  output logic                obi_req_o,
  input  logic                obi_gnt_i,
  output logic [31:0]         obi_addr_o,
  output logic                obi_we_o,
  output logic [3:0]          obi_be_o,
  output logic [31:0]         obi_wdata_o,
  input  logic                obi_rvalid_i,
  input  logic [31:0]         obi_rdata_i,
  input  logic                obi_err_i,
  output logic                busy_o,
  output logic                err_o
);

  localparam int unsigned IdxW  = $clog2(NumReq);
  localparam int unsigned CredW = $clog2(FifoDepth + 1);
  localparam int unsigned GapW  = $clog2(PollGap + 1);

  localparam logic [31:0]      ThrAddr  = BaseAddr + 32'h0000_0000;
  localparam logic [31:0]      LsrAddr  = BaseAddr + 32'h0000_0014;
  localparam logic [IdxW-1:0]  LastRst  = IdxW'(NumReq - 1);
  localparam logic [CredW-1:0] CredZero = {CredW{1'b0}};
  localparam logic [CredW-1:0] CredOne  = CredW'(1'b1);
  localparam logic [CredW-1:0] CredFull = CredW'(FifoDepth);
  localparam logic [GapW-1:0]  GapZero  = {GapW{1'b0}};
  localparam logic [GapW-1:0]  GapOne   = GapW'(1'b1);
  localparam logic [GapW-1:0]  GapLoad  = GapW'(PollGap);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARB       = 3'd1,
    ST_WR_REQ    = 3'd2,
    ST_WR_RSP    = 3'd3,
    ST_POLL_REQ  = 3'd4,
    ST_POLL_RSP  = 3'd5,
    ST_POLL_WAIT = 3'd6
  } state_t;

  state_t           state_r;
  logic [CredW-1:0] credit_r;
  logic [IdxW-1:0]  last_r;
  logic [GapW-1:0]  gap_r;
  logic             obi_req_r;
  logic [31:0]      obi_addr_r;
  logic             obi_we_r;
  logic [3:0]       obi_be_r;
  logic [31:0]      obi_wdata_r;
  logic             err_r;

  logic [IdxW-1:0]   rr_winner_s;
  logic              rr_found_s;
  logic [IdxW-1:0]   cand_s;
  logic [IdxW-1:0]   winner_s;
  logic              found_s;
  logic              upd_last_s;
  logic              any_valid_s;
  logic [7:0]        sel_byte_s;
  logic [NumReq-1:0] ready_s;
  logic              unused_rdata_s;

  assign any_valid_s = |req_valid_i;
  // Only THRE is consumed from the LSR read data.
  assign unused_rdata_s = ^{obi_rdata_i[31:6], obi_rdata_i[4:0]};

  // Round-robin search starting one past the last winner, wrapping around.
  always_comb begin
    rr_winner_s = last_r;
    rr_found_s  = 1'b0;
    cand_s      = last_r;
    for (int i = 1; i <= int'(NumReq); i++) begin
      cand_s = IdxW'((int'(last_r) + i) % int'(NumReq));
      if (!rr_found_s && req_valid_i[cand_s]) begin
        rr_found_s  = 1'b1;
        rr_winner_s = cand_s;
      end else begin
        rr_found_s  = rr_found_s;
      end
    end
  end

`ifdef OBI_UART_TX_ARB_PRIO_EN
  // Requester 0 bypasses the rotation and never moves the pointer.
  assign winner_s   = req_valid_i[0] ? {IdxW{1'b0}} : rr_winner_s;
  assign found_s    = req_valid_i[0] | rr_found_s;
  assign upd_last_s = ~req_valid_i[0];
`else
  assign winner_s   = rr_winner_s;
  assign found_s    = rr_found_s;
  assign upd_last_s = 1'b1;
`endif

  assign sel_byte_s = req_data_i[{winner_s, 3'b000} +: 8];

  // Acceptance strobe: must be combinational so it lands in the ARB cycle itself.
  always_comb begin
    ready_s = {NumReq{1'b0}};
    if (state_r == ST_ARB && credit_r != CredZero && found_s) begin
      ready_s[winner_s] = 1'b1;
    end else begin
      ready_s = {NumReq{1'b0}};
    end
  end

  // Sequencer: state, credit, pointer, poll gap and the registered OBI request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      credit_r    <= CredZero;
      last_r      <= LastRst;
      gap_r       <= GapZero;
      obi_req_r   <= 1'b0;
      obi_addr_r  <= 32'h0000_0000;
      obi_we_r    <= 1'b0;
      obi_be_r    <= 4'b0000;
      obi_wdata_r <= 32'h0000_0000;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_valid_s && credit_r == CredZero) begin
            state_r     <= ST_POLL_REQ;
            obi_req_r   <= 1'b1;
            obi_addr_r  <= LsrAddr;
            obi_we_r    <= 1'b0;
            obi_be_r    <= 4'b1111;
            obi_wdata_r <= 32'h0000_0000;
          end else if (any_valid_s) begin
            state_r <= ST_ARB;
          end
        end
        ST_ARB: begin
          if (!any_valid_s) begin
            state_r <= ST_IDLE;
          end else if (credit_r == CredZero) begin
            state_r     <= ST_POLL_REQ;
            obi_req_r   <= 1'b1;
            obi_addr_r  <= LsrAddr;
            obi_we_r    <= 1'b0;
            obi_be_r    <= 4'b1111;
            obi_wdata_r <= 32'h0000_0000;
          end else begin
            if (upd_last_s) begin
              last_r <= winner_s;
            end
            state_r     <= ST_WR_REQ;
            obi_req_r   <= 1'b1;
            obi_addr_r  <= ThrAddr;
            obi_we_r    <= 1'b1;
            obi_be_r    <= 4'b0001;
            obi_wdata_r <= {24'h00_0000, sel_byte_s};
          end
        end
        ST_WR_REQ: begin
          if (obi_gnt_i) begin
            obi_req_r <= 1'b0;
            credit_r  <= credit_r - CredOne;
            state_r   <= ST_WR_RSP;
          end
        end
        ST_WR_RSP: begin
          // A failed write is dropped; its credit stays consumed.
          if (obi_rvalid_i) begin
            err_r   <= err_r | obi_err_i;
            state_r <= ST_ARB;
          end
        end
        ST_POLL_REQ: begin
          if (obi_gnt_i) begin
            obi_req_r <= 1'b0;
            state_r   <= ST_POLL_RSP;
          end
        end
        ST_POLL_RSP: begin
          if (obi_rvalid_i && !obi_err_i && obi_rdata_i[5]) begin
            credit_r <= CredFull;
            state_r  <= ST_ARB;
          end else if (obi_rvalid_i) begin
            // An erroring poll is treated as THRE=0.
            err_r   <= err_r | obi_err_i;
            gap_r   <= GapLoad;
            state_r <= ST_POLL_WAIT;
          end
        end
        ST_POLL_WAIT: begin
          // Leaving at 1 gives exactly PollGap idle cycles before the next poll.
          if (gap_r <= GapOne) begin
            gap_r       <= GapZero;
            state_r     <= ST_POLL_REQ;
            obi_req_r   <= 1'b1;
            obi_addr_r  <= LsrAddr;
            obi_we_r    <= 1'b0;
            obi_be_r    <= 4'b1111;
            obi_wdata_r <= 32'h0000_0000;
          end else begin
            gap_r <= gap_r - GapOne;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          obi_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = ready_s;
  assign obi_req_o   = obi_req_r;
  assign obi_addr_o  = obi_addr_r;
  assign obi_we_o    = obi_we_r;
  assign obi_be_o    = obi_be_r;
  assign obi_wdata_o = obi_wdata_r;
  assign busy_o      = (state_r != ST_IDLE);
  assign err_o       = err_r;

endmodule
